// File: rtl/ark_serial_engine.sv
// rtl/ark_serial_engine.sv - serial AES AddRoundKey engine with a bank of round keys
// Optional key zeroize port and logic are enabled by defining ARK_KEY_ZEROIZE_EN.
module ark_serial_engine #(
  parameter int DATA_W = 128,
  parameter int LANE_W = 32,
  parameter int NUM_KEYS = 11,
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_wr_en,
  input  logic [IDX_W-1:0]  key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef ARK_KEY_ZEROIZE_EN
  input  logic              key_clear,
`endif
  output logic              round_err
);

  localparam int BEATS = DATA_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam logic [IDX_W:0] NUM_KEYS_X = (IDX_W + 1)'(NUM_KEYS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] work_data;
  logic [DATA_W-1:0] work_key;
  logic [DATA_W-1:0] work_next;
  logic [DATA_W-1:0] key_mem [SLOTS];
  logic [SLOTS-1:0]  key_vld;
  logic              zeroize;
  logic              accept;
  logic              last_beat;
  logic              wr_in_range;
  logic              sel_ok;

`ifdef ARK_KEY_ZEROIZE_EN
  assign zeroize = key_clear;
`else
  assign zeroize = 1'b0;
`endif

  assign accept      = in_valid & in_ready;
  assign last_beat   = (state == S_BUSY) && (beat_cnt == LAST_CNT);
  assign wr_in_range = {1'b0, key_wr_idx} < NUM_KEYS_X;
  // Out-of-range or never-written slots select an all-zero key (pass-through).
  assign sel_ok      = ({1'b0, in_round} < NUM_KEYS_X) && key_vld[in_round];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (zeroize) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (in_valid)  state_next = S_BUSY;
        S_BUSY:  if (last_beat) state_next = S_DONE;
        S_DONE:  if (out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Key bank: slots beyond NUM_KEYS exist only to keep indexing full-width and are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) key_mem[i] <= '0;
      key_vld <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < SLOTS; i++) key_mem[i] <= '0;
      key_vld <= '0;
    end else if (key_wr_en && wr_in_range) begin
      key_mem[key_wr_idx] <= key_wr_data;
      key_vld[key_wr_idx] <= 1'b1;
    end
  end

  always_comb begin
    work_next = work_data;
    for (int g = 0; g < BEATS; g++) begin
      if (beat_cnt == CNT_W'(g)) begin
        work_next[g*LANE_W +: LANE_W] = work_data[g*LANE_W +: LANE_W] ^ work_key[g*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_data <= '0;
      work_key  <= '0;
      beat_cnt  <= '0;
      out_data  <= '0;
      round_err <= 1'b0;
    end else if (zeroize) begin
      work_data <= '0;
      work_key  <= '0;
      beat_cnt  <= '0;
      out_data  <= '0;
      round_err <= 1'b0;
    end else if (accept) begin
      work_data <= in_data;
      work_key  <= sel_ok ? key_mem[in_round] : '0;
      beat_cnt  <= '0;
      if (!sel_ok) round_err <= 1'b1;
    end else if (state == S_BUSY) begin
      work_data <= work_next;
      if (last_beat) begin
        beat_cnt <= '0;
        out_data <= work_next;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ark_serial_engine.sv
// tb/tb_ark_serial_engine.sv - directed self-checking bench for ark_serial_engine
// Covers LANE_W 32/128/8 instances; zeroize steps run when ARK_KEY_ZEROIZE_EN is defined.
module tb_ark_serial_engine;

  localparam logic [127:0] K0       = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_OUT = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] ONES     = {128{1'b1}};
  localparam logic [127:0] NOT_K0   = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
  localparam logic [127:0] NOT_FIPS = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] ERR_D1   = 128'hdeadbeef0badf00dcafebabe12345678;
  localparam logic [127:0] ERR_D2   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_wr_en;
  logic [3:0]   key_wr_idx;
  logic [127:0] key_wr_data;
  logic [127:0] in_data;
  logic [3:0]   in_round;
  logic [2:0]   iv, ordy, ir, ov, re;
  logic [127:0] od0, od1, od2;
`ifdef ARK_KEY_ZEROIZE_EN
  logic         key_clear;
`endif

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ark_serial_engine #(.DATA_W(128), .LANE_W(32), .NUM_KEYS(11)) u_dut32 (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data), .in_round(in_round),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
`ifdef ARK_KEY_ZEROIZE_EN
    .key_clear(key_clear),
`endif
    .round_err(re[0]));

  ark_serial_engine #(.DATA_W(128), .LANE_W(128), .NUM_KEYS(11)) u_dut128 (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data), .in_round(in_round),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
`ifdef ARK_KEY_ZEROIZE_EN
    .key_clear(key_clear),
`endif
    .round_err(re[1]));

  ark_serial_engine #(.DATA_W(128), .LANE_W(8), .NUM_KEYS(11)) u_dut8 (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data), .in_round(in_round),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2),
`ifdef ARK_KEY_ZEROIZE_EN
    .key_clear(key_clear),
`endif
    .round_err(re[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] data_of(input int d);
    case (d)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  task automatic write_key(input logic [3:0] idx, input logic [127:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = data;
    step();
    key_wr_en   = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!ov[d] && lat < 64);
  endtask

  task automatic send(input int d, input logic [127:0] data, input logic [3:0] rnd, input string tag);
    in_data  = data;
    in_round = rnd;
    iv[d]    = 1'b1;
    chk({tag, "_ready_pre"}, 128'(ir[d]), 128'd1);
    step();
    iv[d]    = 1'b0;
    chk({tag, "_ready_busy"}, 128'(ir[d]), 128'd0);
  endtask

  task automatic run(input int d, input logic [127:0] data, input logic [3:0] rnd,
                     input int exp_lat, input logic [127:0] exp, input string tag);
    int lat;
    ordy[d] = 1'b1;
    send(d, data, rnd, tag);
    wait_valid(d, lat);
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_data"}, data_of(d), exp);
    step();
    chk({tag, "_ready_after"}, 128'(ir[d]), 128'd1);
    chk({tag, "_valid_after"}, 128'(ov[d]), 128'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    in_data = '0; in_round = '0; iv = '0; ordy = 3'b111;
`ifdef ARK_KEY_ZEROIZE_EN
    key_clear = 1'b0;
`endif
    step();
    step();
    chk("rst_ready", 128'(ir), 128'h7);
    chk("rst_valid", 128'(ov), 128'h0);
    chk("rst_data", od0 | od1 | od2, 128'h0);
    chk("rst_err", 128'(re), 128'h0);
    rst = 1'b0;

    write_key(4'd0, K0);
    run(0, FIPS_IN, 4'd0, 4, FIPS_OUT, "fips32");

    // Backpressure with a competing in_valid that must be ignored
    ordy[0] = 1'b0;
    send(0, ONES, 4'd0, "bp");
    wait_valid(0, lat);
    chk("bp_lat", 128'(lat), 128'd4);
    iv[0] = 1'b1;
    in_data = ERR_D1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_data", od0, NOT_K0);
      chk("bp_valid", 128'(ov[0]), 128'd1);
      chk("bp_ready", 128'(ir[0]), 128'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    step();
    chk("bp_ready_after", 128'(ir[0]), 128'd1);
    chk("bp_data_kept", od0, NOT_K0);

    // Key rewrite on the accept edge and again while busy
    in_data = FIPS_IN; in_round = 4'd0; iv[0] = 1'b1;
    key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = ONES;
    step();
    iv[0] = 1'b0;
    step();
    key_wr_en = 1'b0;
    wait_valid(0, lat);
    chk("hazard_data", od0, FIPS_OUT);
    step();
    run(0, FIPS_IN, 4'd0, 4, NOT_FIPS, "newkey");
    write_key(4'd0, K0);

    chk("err_clear", 128'(re[0]), 128'd0);
    run(0, ERR_D1, 4'd11, 4, ERR_D1, "err11");
    chk("err_set11", 128'(re[0]), 128'd1);
    run(0, ERR_D2, 4'd5, 4, ERR_D2, "err5");
    chk("err_set5", 128'(re[0]), 128'd1);
    run(0, FIPS_IN, 4'd0, 4, FIPS_OUT, "err_good");
    chk("err_sticky", 128'(re[0]), 128'd1);

    // Asynchronous reset during beat 2
    send(0, FIPS_IN, 4'd0, "midrst");
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_ready", 128'(ir[0]), 128'd1);
    chk("midrst_valid", 128'(ov[0]), 128'd0);
    chk("midrst_data", od0, 128'h0);
    chk("midrst_err", 128'(re[0]), 128'd0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_no_out", 128'(ov[0]), 128'd0);

    write_key(4'd0, K0);
    run(0, FIPS_IN, 4'd0, 4, FIPS_OUT, "lane32");
    run(1, FIPS_IN, 4'd0, 1, FIPS_OUT, "lane128");
    run(2, FIPS_IN, 4'd0, 16, FIPS_OUT, "lane8");

`ifdef ARK_KEY_ZEROIZE_EN
    send(0, FIPS_IN, 4'd0, "zero");
    step();
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    chk("zero_ready", 128'(ir[0]), 128'd1);
    chk("zero_valid", 128'(ov[0]), 128'd0);
    chk("zero_data", od0, 128'h0);
    for (int i = 0; i < 6; i++) step();
    chk("zero_no_out", 128'(ov[0]), 128'd0);
    run(0, FIPS_IN, 4'd0, 4, FIPS_IN, "zero_pass");
    chk("zero_err", 128'(re[0]), 128'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
